// File: rtl/oisc8_pkg.sv
// Shared types and bus map for the OISC-8 ALU neighbourhood, including the
// sequential multiply/divide unit.
package oisc8_pkg;

    typedef enum logic [1:0] {
        MD_MUL  = 2'b00,
        MD_MULS = 2'b01,
        MD_DIV  = 2'b10,
        MD_DIVS = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_FIX,
        MD_DONE
    } muldiv_state_t;

    // Bus glue addresses: operands and op are write ports, status/results read ports.
    localparam logic [7:0] MD_ADDR_A      = 8'hE0;
    localparam logic [7:0] MD_ADDR_B      = 8'hE1;
    localparam logic [7:0] MD_ADDR_OP     = 8'hE2;
    localparam logic [7:0] MD_ADDR_STATUS = 8'hE3;
    localparam logic [7:0] MD_ADDR_RES_LO = 8'hE4;
    localparam logic [7:0] MD_ADDR_RES_HI = 8'hE5;

    localparam int MD_STATUS_BUSY_BIT = 0;
    localparam int MD_STATUS_DONE_BIT = 1;
    localparam int MD_STATUS_DBZ_BIT  = 2;

endpackage

// File: rtl/oisc_seq_muldiv_twos_mag.sv
// Two's-complement magnitude helper: negates the value when the sign flag is
// set, so the same block serves operand entry and result fix-up.
module twos_mag #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] mag
);

    always_comb mag = neg ? -value : value;

endmodule

// File: rtl/oisc_seq_muldiv.sv
// Radix-2 sequential multiply/divide unit: one result bit per clock, signed
// operands handled as magnitudes with a single sign fix-up cycle at the end.
module oisc_seq_muldiv
    import oisc8_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    muldiv_state_t     state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic              accept;

    muldiv_op_t        op_in;
    logic              in_signed, in_sign_a, in_sign_b;
    logic [WIDTH-1:0]  mag_a, mag_b;

    logic [WIDTH-1:0]  acc_hi, acc_lo, opnd, a_raw;
    logic              is_div, b_zero, sign_a, sign_b;

    logic [WIDTH:0]    mul_sum;
    logic [WIDTH+1:0]  div_diff;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign op_in  = muldiv_op_t'(op);
    assign accept = start && (state == MD_IDLE || state == MD_DONE);

    always_comb begin
        in_signed = SIGNED_EN && (op_in == MD_MULS || op_in == MD_DIVS);
        in_sign_a = in_signed && a[WIDTH-1];
        in_sign_b = in_signed && b[WIDTH-1];
    end

    twos_mag #(.WIDTH(WIDTH)) u_mag_a (.value(a), .neg(in_sign_a), .mag(mag_a));
    twos_mag #(.WIDTH(WIDTH)) u_mag_b (.value(b), .neg(in_sign_b), .mag(mag_b));

    always_comb begin
        state_n = state;
        case (state)
            MD_IDLE: if (start) state_n = MD_CALC;
            MD_CALC: if (cnt == CNT_LAST) state_n = MD_FIX;
            MD_FIX:  state_n = MD_DONE;
            MD_DONE: state_n = start ? MD_CALC : MD_IDLE;
            default: state_n = MD_IDLE;
        endcase
    end

    // busy/done are registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MD_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            busy  <= (state_n == MD_CALC) || (state_n == MD_FIX);
            done  <= (state_n == MD_DONE);
            if (state == MD_CALC)
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            else
                cnt <= '0;
        end
    end

    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_diff = {1'b0, acc_hi, acc_lo[WIDTH-1]} - {2'b00, opnd};
    end

    // acc_lo holds multiplier (shifted out) or dividend/quotient; acc_hi holds
    // partial product high half or the running remainder.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_hi <= '0;
            acc_lo <= mag_a;
            opnd   <= mag_b;
            a_raw  <= a;
            b_zero <= (b == '0);
            is_div <= op[1];
            sign_a <= in_sign_a;
            sign_b <= in_sign_b;
        end else if (state == MD_CALC) begin
            if (!is_div) begin
                acc_hi <= mul_sum[WIDTH:1];
                acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end else if (!div_diff[WIDTH+1]) begin
                acc_hi <= div_diff[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi <= {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    twos_mag #(.WIDTH(2*WIDTH)) u_fix_prod (.value({acc_hi, acc_lo}), .neg(sign_a ^ sign_b), .mag(prod_fix));
    twos_mag #(.WIDTH(WIDTH))   u_fix_quo  (.value(acc_lo), .neg(sign_a ^ sign_b), .mag(quo_fix));
    twos_mag #(.WIDTH(WIDTH))   u_fix_rem  (.value(acc_hi), .neg(sign_a), .mag(rem_fix));

    // Most-negative / -1 needs no special path: the wrapped quotient magnitude
    // is already the most-negative pattern and the remainder is zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
        end else if (state == MD_FIX) begin
            if (!is_div) begin
                {result_hi, result_lo} <= prod_fix;
                div_by_zero            <= 1'b0;
            end else if (b_zero) begin
                result_lo   <= '1;
                result_hi   <= a_raw;
                div_by_zero <= 1'b1;
            end else begin
                result_lo   <= quo_fix;
                result_hi   <= rem_fix;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_oisc_seq_muldiv.sv
// Bench for oisc_seq_muldiv: directed scenarios plus randomized ops checked
// against an arithmetic reference model, for signed and unsigned-only builds.
module tb_oisc_seq_muldiv;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;

    logic         busy, done, dbz;
    logic [W-1:0] res_lo, res_hi;
    logic         u_busy, u_done, u_dbz;
    logic [W-1:0] u_res_lo, u_res_hi;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    oisc_seq_muldiv #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result_lo(res_lo), .result_hi(res_hi),
        .div_by_zero(dbz)
    );

    oisc_seq_muldiv #(.WIDTH(W), .SIGNED_EN(1'b0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(u_busy), .done(u_done), .result_lo(u_res_lo), .result_hi(u_res_hi),
        .div_by_zero(u_dbz)
    );

    function automatic void ref_model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                                      input bit se, output logic [7:0] lo, output logic [7:0] hi,
                                      output logic dz);
        longint sx, sy, p, q, r;
        bit sg;
        sg = se && o[0];
        sx = sg ? longint'($signed(x)) : longint'(x);
        sy = sg ? longint'($signed(y)) : longint'(y);
        if (!o[1]) begin
            p  = sx * sy;
            lo = p[7:0];
            hi = p[15:8];
            dz = 1'b0;
        end else if (y == 8'h00) begin
            lo = 8'hFF;
            hi = x;
            dz = 1'b1;
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            lo = q[7:0];
            hi = r[7:0];
            dz = 1'b0;
        end
    endfunction

    // Issues one op from idle and waits (bounded) for done; reports cycles from
    // the start cycle to the done cycle and the number of busy cycles seen.
    task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                          output int lat, output int busy_cnt);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        lat = 0;
        busy_cnt = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (busy) busy_cnt++;
        end while (!done && lat < 40);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        compared++; if (busy !== 1'b0)   begin mismatched++; $display("FAIL reset_busy got=%b want=0", busy); end
        compared++; if (done !== 1'b0)   begin mismatched++; $display("FAIL reset_done got=%b want=0", done); end
        compared++; if (res_lo !== 8'h00) begin mismatched++; $display("FAIL reset_lo got=%h want=00", res_lo); end
        compared++; if (res_hi !== 8'h00) begin mismatched++; $display("FAIL reset_hi got=%h want=00", res_hi); end
        compared++; if (dbz !== 1'b0)    begin mismatched++; $display("FAIL reset_dbz got=%b want=0", dbz); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        int lat, bc;
        run_op(2'b00, 8'd200, 8'd100, lat, bc);
        compared++; if (lat !== 10)      begin mismatched++; $display("FAIL mul_latency got=%0d want=10", lat); end
        compared++; if (bc !== 9)        begin mismatched++; $display("FAIL mul_busy_cycles got=%0d want=9", bc); end
        compared++; if (busy !== 1'b0)   begin mismatched++; $display("FAIL mul_busy_in_done got=%b want=0", busy); end
        compared++; if (res_hi !== 8'h4E) begin mismatched++; $display("FAIL mul_hi got=%h want=4e", res_hi); end
        compared++; if (res_lo !== 8'h20) begin mismatched++; $display("FAIL mul_lo got=%h want=20", res_lo); end
        compared++; if (dbz !== 1'b0)    begin mismatched++; $display("FAIL mul_dbz got=%b want=0", dbz); end
        @(posedge clk); #1;
        compared++; if (done !== 1'b0)   begin mismatched++; $display("FAIL mul_done_pulse got=%b want=0", done); end
    endtask

    task automatic test_signed();
        int lat, bc;
        run_op(2'b01, 8'hFD, 8'h05, lat, bc);
        compared++; if (res_hi !== 8'hFF) begin mismatched++; $display("FAIL muls_hi got=%h want=ff", res_hi); end
        compared++; if (res_lo !== 8'hF1) begin mismatched++; $display("FAIL muls_lo got=%h want=f1", res_lo); end
        run_op(2'b11, 8'hF9, 8'h02, lat, bc);
        compared++; if (res_lo !== 8'hFD) begin mismatched++; $display("FAIL divs_quo got=%h want=fd", res_lo); end
        compared++; if (res_hi !== 8'hFF) begin mismatched++; $display("FAIL divs_rem got=%h want=ff", res_hi); end
        compared++; if (lat !== 10)       begin mismatched++; $display("FAIL divs_latency got=%0d want=10", lat); end
    endtask

    task automatic test_div_and_zero();
        int lat, bc;
        run_op(2'b10, 8'd200, 8'd7, lat, bc);
        compared++; if (res_lo !== 8'h1C) begin mismatched++; $display("FAIL div_quo got=%h want=1c", res_lo); end
        compared++; if (res_hi !== 8'h04) begin mismatched++; $display("FAIL div_rem got=%h want=04", res_hi); end
        run_op(2'b10, 8'h55, 8'h00, lat, bc);
        compared++; if (lat !== 10)       begin mismatched++; $display("FAIL dbz_latency got=%0d want=10", lat); end
        compared++; if (res_lo !== 8'hFF) begin mismatched++; $display("FAIL dbz_lo got=%h want=ff", res_lo); end
        compared++; if (res_hi !== 8'h55) begin mismatched++; $display("FAIL dbz_hi got=%h want=55", res_hi); end
        compared++; if (dbz !== 1'b1)     begin mismatched++; $display("FAIL dbz_flag got=%b want=1", dbz); end
        run_op(2'b00, 8'd2, 8'd3, lat, bc);
        compared++; if (dbz !== 1'b0)     begin mismatched++; $display("FAIL dbz_clear got=%b want=0", dbz); end
        compared++; if (res_lo !== 8'h06) begin mismatched++; $display("FAIL mul23_lo got=%h want=06", res_lo); end
        compared++; if (res_hi !== 8'h00) begin mismatched++; $display("FAIL mul23_hi got=%h want=00", res_hi); end
    endtask

    task automatic test_overflow();
        int lat, bc;
        run_op(2'b11, 8'h80, 8'hFF, lat, bc);
        compared++; if (res_lo !== 8'h80)   begin mismatched++; $display("FAIL ovf_quo got=%h want=80", res_lo); end
        compared++; if (res_hi !== 8'h00)   begin mismatched++; $display("FAIL ovf_rem got=%h want=00", res_hi); end
        compared++; if (dbz !== 1'b0)       begin mismatched++; $display("FAIL ovf_dbz got=%b want=0", dbz); end
        compared++; if (u_done !== 1'b1)    begin mismatched++; $display("FAIL uns_done got=%b want=1", u_done); end
        compared++; if (u_res_lo !== 8'h00) begin mismatched++; $display("FAIL uns_quo got=%h want=00", u_res_lo); end
        compared++; if (u_res_hi !== 8'h80) begin mismatched++; $display("FAIL uns_rem got=%h want=80", u_res_hi); end
    endtask

    task automatic test_start_ignored();
        int cyc;
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; a = 8'd3; b = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        repeat (4) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b1; op = 2'b10; a = 8'd9; b = 8'd3;
        end
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        compared++; if (cyc !== 10)       begin mismatched++; $display("FAIL ign_done_cycle got=%0d want=10", cyc); end
        compared++; if (res_lo !== 8'h0C) begin mismatched++; $display("FAIL ign_lo got=%h want=0c", res_lo); end
        compared++; if (res_hi !== 8'h00) begin mismatched++; $display("FAIL ign_hi got=%h want=00", res_hi); end
        start = 1'b1; op = 2'b10; a = 8'd9; b = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
        compared++; if (busy !== 1'b1)    begin mismatched++; $display("FAIL restart_busy got=%b want=1", busy); end
        while (!done && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        compared++; if (cyc !== 20)       begin mismatched++; $display("FAIL restart_done_cycle got=%0d want=20", cyc); end
        compared++; if (res_lo !== 8'h03) begin mismatched++; $display("FAIL restart_lo got=%h want=03", res_lo); end
        compared++; if (res_hi !== 8'h00) begin mismatched++; $display("FAIL restart_hi got=%h want=00", res_hi); end
    endtask

    task automatic test_rst_abort();
        int lat, bc;
        bit seen;
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; a = 8'd15; b = 8'd15;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compared++; if (busy !== 1'b1)    begin mismatched++; $display("FAIL abort_busy_before got=%b want=1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        compared++; if (busy !== 1'b0)    begin mismatched++; $display("FAIL abort_busy got=%b want=0", busy); end
        compared++; if (done !== 1'b0)    begin mismatched++; $display("FAIL abort_done got=%b want=0", done); end
        compared++; if (res_lo !== 8'h00) begin mismatched++; $display("FAIL abort_lo got=%h want=00", res_lo); end
        compared++; if (res_hi !== 8'h00) begin mismatched++; $display("FAIL abort_hi got=%h want=00", res_hi); end
        compared++; if (dbz !== 1'b0)     begin mismatched++; $display("FAIL abort_dbz got=%b want=0", dbz); end
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        compared++; if (seen !== 1'b0)    begin mismatched++; $display("FAIL abort_quiet got=%b want=0", seen); end
        run_op(2'b00, 8'd15, 8'd15, lat, bc);
        compared++; if (lat !== 10)       begin mismatched++; $display("FAIL fresh_latency got=%0d want=10", lat); end
        compared++; if ({res_hi, res_lo} !== 16'h00E1) begin mismatched++; $display("FAIL fresh_result got=%h want=00e1", {res_hi, res_lo}); end
    endtask

    task automatic test_random();
        int lat, bc;
        logic [1:0] o;
        logic [7:0] x, y, elo, ehi, ulo, uhi;
        logic edz, udz;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom);
            x = 8'($urandom);
            y = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            ref_model(o, x, y, 1'b1, elo, ehi, edz);
            ref_model(o, x, y, 1'b0, ulo, uhi, udz);
            run_op(o, x, y, lat, bc);
            compared++; if (lat !== 10) begin mismatched++; $display("FAIL rnd_latency op=%0d a=%h b=%h got=%0d want=10", o, x, y, lat); end
            compared++; if ({res_hi, res_lo, dbz} !== {ehi, elo, edz}) begin mismatched++; $display("FAIL rnd_signed op=%0d a=%h b=%h got=%h_%h_%b want=%h_%h_%b", o, x, y, res_hi, res_lo, dbz, ehi, elo, edz); end
            compared++; if ({u_res_hi, u_res_lo, u_dbz} !== {uhi, ulo, udz}) begin mismatched++; $display("FAIL rnd_unsigned op=%0d a=%h b=%h got=%h_%h_%b want=%h_%h_%b", o, x, y, u_res_hi, u_res_lo, u_dbz, uhi, ulo, udz); end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [1:0] o;
        logic [7:0] x, y, elo, ehi;
        logic edz;
        @(posedge clk); #1;
        o = 2'($urandom); x = 8'($urandom); y = 8'($urandom);
        start = 1'b1; op = o; a = x; b = y;
        for (int k = 0; k < 12; k++) begin
            ref_model(o, x, y, 1'b1, elo, ehi, edz);
            cyc = 0;
            do begin
                @(posedge clk); #1;
                start = 1'b0;
                cyc++;
            end while (!done && cyc < 40);
            compared++; if (cyc !== 10) begin mismatched++; $display("FAIL b2b_latency k=%0d got=%0d want=10", k, cyc); end
            compared++; if ({res_hi, res_lo, dbz} !== {ehi, elo, edz}) begin mismatched++; $display("FAIL b2b_result k=%0d op=%0d a=%h b=%h got=%h_%h_%b want=%h_%h_%b", k, o, x, y, res_hi, res_lo, dbz, ehi, elo, edz); end
            if (k < 11) begin
                o = 2'($urandom); x = 8'($urandom);
                y = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
                start = 1'b1; op = o; a = x; b = y;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_signed();
        test_div_and_zero();
        test_overflow();
        test_start_ignored();
        test_rst_abort();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
